// File: rtl/serial_paralelo_rx_param_if.sv
// Serial RX bus bundle: serial bit in, aligned word plus status out.
// master = bit source / word consumer, slave = deserialiser.
interface serial_paralelo_rx_param_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic [WIDTH-1:0] sp_out;
  logic             valid_out_sp;
  logic             active;
  logic             word_tick;

  modport master (
    output data_in,
    input  sp_out, valid_out_sp, active, word_tick
  );

  modport slave (
    input  data_in,
    output sp_out, valid_out_sp, active, word_tick
  );
endinterface

// File: rtl/serial_paralelo_rx_param.sv
// Serial-to-parallel RX deserialiser with comma alignment and lock detection.
// Optional macro SP_RX_RESYNC_EN: drop lock after MAX_GAP words without a comma.
module serial_paralelo_rx_param #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = WIDTH'(8'hBC),
  parameter int               LOCK_COUNT = 4,
  parameter int               MAX_GAP    = 16
) (
  input  logic                         clk_32f,
  input  logic                         rst,
  serial_paralelo_rx_param_if.slave    bus
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [BW-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0]       r_comma_cnt, w_comma_cnt_nxt;
  logic [WIDTH-1:0] r_sp_out, w_sp_out_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_active, w_active_nxt;
  logic             r_tick, w_tick_nxt;

  logic [WIDTH-1:0] w_nxt;
  logic             w_boundary;
  logic             w_is_comma;
  logic [3:0]       w_comma_inc;

`ifdef SP_RX_RESYNC_EN
  localparam int GW = $clog2(MAX_GAP + 1);
  logic [GW-1:0] r_gap_cnt, w_gap_cnt_nxt;
  logic [GW:0]   w_gap_inc;
`endif

  assign w_nxt       = {r_shreg[WIDTH-2:0], bus.data_in};
  assign w_boundary  = (r_bit_cnt == BW'(WIDTH - 1));
  assign w_is_comma  = (w_nxt == COMMA);
  assign w_comma_inc = r_comma_cnt + 4'd1;
`ifdef SP_RX_RESYNC_EN
  assign w_gap_inc   = {1'b0, r_gap_cnt} + 1'b1;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_comma_cnt_nxt = r_comma_cnt;
    w_sp_out_nxt    = r_sp_out;
    w_valid_nxt     = r_valid;
    w_active_nxt    = r_active;
    w_tick_nxt      = 1'b0;
`ifdef SP_RX_RESYNC_EN
    w_gap_cnt_nxt   = r_gap_cnt;
`endif
    case (r_state)
      SEARCH: begin
        // Slide one bit per cycle; the comma itself defines the word boundary.
        w_bit_cnt_nxt = '0;
        if (w_is_comma) begin
          w_comma_cnt_nxt = 4'd1;
          if (LOCK_COUNT == 1) begin
            w_state_nxt  = ACTIVE;
            w_active_nxt = 1'b1;
          end else begin
            w_state_nxt = SYNC;
          end
        end
      end
      SYNC: begin
        w_bit_cnt_nxt = w_boundary ? '0 : r_bit_cnt + 1'b1;
        if (w_boundary) begin
          w_tick_nxt = 1'b1;
          if (w_is_comma) begin
            w_comma_cnt_nxt = w_comma_inc;
            if (w_comma_inc == 4'(LOCK_COUNT)) begin
              w_state_nxt  = ACTIVE;
              w_active_nxt = 1'b1;
            end
          end else begin
            w_state_nxt     = SEARCH;
            w_comma_cnt_nxt = '0;
          end
        end
      end
      ACTIVE: begin
        w_bit_cnt_nxt = w_boundary ? '0 : r_bit_cnt + 1'b1;
        if (w_boundary) begin
          w_tick_nxt = 1'b1;
          if (w_is_comma) begin
            w_valid_nxt = 1'b0;
`ifdef SP_RX_RESYNC_EN
            w_gap_cnt_nxt = '0;
`endif
          end else begin
`ifdef SP_RX_RESYNC_EN
            // Too long without a comma: assume misalignment and hunt again.
            if (w_gap_inc == (GW+1)'(MAX_GAP)) begin
              w_state_nxt     = SEARCH;
              w_active_nxt    = 1'b0;
              w_valid_nxt     = 1'b0;
              w_comma_cnt_nxt = '0;
              w_gap_cnt_nxt   = '0;
            end else begin
              w_sp_out_nxt = w_nxt;
              w_valid_nxt  = 1'b1;
              if (r_gap_cnt != '1) begin
                w_gap_cnt_nxt = w_gap_inc[GW-1:0];
              end
            end
`else
            w_sp_out_nxt = w_nxt;
            w_valid_nxt  = 1'b1;
`endif
          end
        end
      end
      default: begin
        w_state_nxt = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (rst) begin
      r_state     <= SEARCH;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_comma_cnt <= '0;
      r_sp_out    <= '0;
      r_valid     <= 1'b0;
      r_active    <= 1'b0;
      r_tick      <= 1'b0;
`ifdef SP_RX_RESYNC_EN
      r_gap_cnt   <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_comma_cnt <= w_comma_cnt_nxt;
      r_sp_out    <= w_sp_out_nxt;
      r_valid     <= w_valid_nxt;
      r_active    <= w_active_nxt;
      r_tick      <= w_tick_nxt;
`ifdef SP_RX_RESYNC_EN
      r_gap_cnt   <= w_gap_cnt_nxt;
`endif
    end
  end

  assign bus.sp_out       = r_sp_out;
  assign bus.valid_out_sp = r_valid;
  assign bus.active       = r_active;
  assign bus.word_tick    = r_tick;

endmodule

// File: tb/tb_serial_paralelo_rx_param.sv
// Directed bench for serial_paralelo_rx_param: vector table for the locked data path,
// hand sequences for alignment offset, lock loss, reset mid-word and long comma gaps.
module tb_serial_paralelo_rx_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_paralelo_rx_param_if #(.WIDTH(8)) busIf ();

  serial_paralelo_rx_param #(
    .WIDTH(8), .COMMA(8'hBC), .LOCK_COUNT(4), .MAX_GAP(16)
  ) dut (
    .clk_32f(clk),
    .rst    (rst),
    .bus    (busIf)
  );

  typedef struct {
    logic [7:0] word;
    logic       expActive;
    logic       expValid;
    logic [7:0] expSp;
    logic       expTick;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic a, input logic v,
                          input logic [7:0] sp, input logic t);
    checkOutput({tag, " active"}, {7'd0, busIf.active}, {7'd0, a});
    checkOutput({tag, " valid"}, {7'd0, busIf.valid_out_sp}, {7'd0, v});
    checkOutput({tag, " sp_out"}, busIf.sp_out, sp);
    checkOutput({tag, " word_tick"}, {7'd0, busIf.word_tick}, {7'd0, t});
  endtask

  task automatic sendBit(input logic b);
    busIf.data_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) sendBit(w[i]);
  endtask

  task automatic doReset();
    rst = 1'b1;
    busIf.data_in = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic lockUp(input string tag);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'hBC);
      checkOutput({tag, " pre-lock active"}, {7'd0, busIf.active}, 8'd0);
    end
    applyStimulus(8'hBC);
    checkOutput({tag, " lock active"}, {7'd0, busIf.active}, 8'd1);
  endtask

  initial begin
    vecs[0] = '{8'hBC, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hBC, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hBC, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[3] = '{8'hBC, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1};
    vecs[6] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1};
    vecs[7] = '{8'hBC, 1'b1, 1'b0, 8'hA5, 1'b1};

    // Reset held with random serial data
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      busIf.data_in = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checkAll("reset", 1'b0, 1'b0, 8'h00, 1'b0);
    end
    rst = 1'b0;

    // Aligned lock, data words, comma after data
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].word);
      checkAll($sformatf("vec%0d", i), vecs[i].expActive, vecs[i].expValid,
               vecs[i].expSp, vecs[i].expTick);
      if (i == 4) begin
        sendBit(1'b0);
        checkOutput("tick one-cycle", {7'd0, busIf.word_tick}, 8'd0);
        checkOutput("sp hold mid-word", busIf.sp_out, 8'hA5);
        for (int k = 0; k < 7; k++) sendBit(1'b0);
        checkOutput("zero word sp", busIf.sp_out, 8'h00);
        applyStimulus(8'hBC);
        checkOutput("comma after zero valid", {7'd0, busIf.valid_out_sp}, 8'd0);
        applyStimulus(8'hA5);
      end
    end

    // Lock at a 3-bit offset
    doReset();
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    applyStimulus(8'hBC);
    checkAll("offset first comma", 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(8'hBC);
    applyStimulus(8'hBC);
    checkOutput("offset 3 commas active", {7'd0, busIf.active}, 8'd0);
    applyStimulus(8'hBC);
    checkOutput("offset lock active", {7'd0, busIf.active}, 8'd1);
    applyStimulus(8'h5A);
    checkAll("offset data", 1'b1, 1'b1, 8'h5A, 1'b1);

    // Broken comma run restarts the lock count
    doReset();
    applyStimulus(8'hBC);
    applyStimulus(8'hBC);
    applyStimulus(8'h00);
    checkAll("break word", 1'b0, 1'b0, 8'h00, 1'b1);
    lockUp("relock");
    applyStimulus(8'h11);
    checkAll("relock data", 1'b1, 1'b1, 8'h11, 1'b1);

    // Reset mid-word while locked
    sendBit(1'b0); sendBit(1'b0); sendBit(1'b0);
    rst = 1'b1;
    busIf.data_in = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkAll("mid-word reset", 1'b0, 1'b0, 8'h00, 1'b0);
    lockUp("post-reset");

    // Long run without commas
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(8'h55);
      checkAll($sformatf("gap word%0d", i), 1'b1, 1'b1, 8'h55, 1'b1);
    end
    applyStimulus(8'h55);
`ifdef SP_RX_RESYNC_EN
    checkAll("gap word16", 1'b0, 1'b0, 8'h55, 1'b1);
`else
    checkAll("gap word16", 1'b1, 1'b1, 8'h55, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
